// File: rtl/input_debounce_array.sv
// Multi-channel input debouncer: per channel a 2-flop synchroniser, stability
// filter, debounced level, rise/fall strobes and long-press/auto-repeat strobes.
module input_debounce_array #(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned STABLE_CYCLES = 1000000,
  parameter int unsigned HOLD_CYCLES   = 50000000,
  parameter int unsigned REPEAT_CYCLES = 10000000,
  parameter bit          ACTIVE_LOW    = 1'b0,
  parameter bit          RESET_LEVEL   = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] i,
  output logic [NUM_CH-1:0] o,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall,
  output logic [NUM_CH-1:0] hold
);

  localparam int unsigned CW          = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned STABLE_LAST = STABLE_CYCLES - 1;
  localparam int unsigned HMAX        = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned HW          = (HMAX > 0) ? $clog2(HMAX + 1) : 1;
  localparam int unsigned HOLD_LAST   = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;
  localparam int unsigned RPT_LAST    = (REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0;
  // Synchroniser reset value chosen so the filtered sample starts at RESET_LEVEL.
  localparam bit          SYNC_RST    = RESET_LEVEL ^ ACTIVE_LOW;

  typedef enum logic [1:0] {
    PH_FIRST  = 2'd0,
    PH_REPEAT = 2'd1,
    PH_DONE   = 2'd2
  } phase_t;

  genvar c;
  for (c = 0; c < NUM_CH; c++) begin : g_ch
    logic          s0;
    logic          s1;
    logic          f;
    logic          o_q;
    logic          rise_q;
    logic          fall_q;
    logic          flip_c;
    logic [CW-1:0] cnt_q;

    assign f      = s1 ^ ACTIVE_LOW;
    assign flip_c = (f != o_q) && (cnt_q == CW'(STABLE_LAST));

    // Synchroniser, stability counter and level/edge registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s0     <= SYNC_RST;
        s1     <= SYNC_RST;
        o_q    <= RESET_LEVEL;
        cnt_q  <= '0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        s0     <= i[c];
        s1     <= s0;
        rise_q <= flip_c & f;
        fall_q <= flip_c & ~f;
        if ((f == o_q) || flip_c) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
        if (flip_c) begin
          o_q <= f;
        end
      end
    end

    assign o[c]    = o_q;
    assign rise[c] = rise_q;
    assign fall[c] = fall_q;

    if (HOLD_CYCLES > 0) begin : g_hold
      phase_t        phase_q;
      phase_t        phase_d;
      logic [HW-1:0] hcnt_q;
      logic [HW-1:0] hcnt_d;
      logic          hold_q;
      logic          hold_d;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          phase_q <= PH_FIRST;
          hcnt_q  <= '0;
          hold_q  <= 1'b0;
        end else begin
          phase_q <= phase_d;
          hcnt_q  <= hcnt_d;
          hold_q  <= hold_d;
        end
      end

      // A falling edge (o high and flipping) restarts the press and drops any due strobe.
      always_comb begin
        phase_d = phase_q;
        hcnt_d  = hcnt_q;
        hold_d  = 1'b0;
        if (!o_q || flip_c) begin
          phase_d = PH_FIRST;
          hcnt_d  = '0;
        end else begin
          case (phase_q)
            PH_FIRST: begin
              if (hcnt_q == HW'(HOLD_LAST)) begin
                hold_d  = 1'b1;
                hcnt_d  = '0;
                phase_d = (REPEAT_CYCLES > 0) ? PH_REPEAT : PH_DONE;
              end else begin
                hcnt_d = hcnt_q + HW'(1);
              end
            end
            PH_REPEAT: begin
              if (hcnt_q == HW'(RPT_LAST)) begin
                hold_d = 1'b1;
                hcnt_d = '0;
              end else begin
                hcnt_d = hcnt_q + HW'(1);
              end
            end
            default: begin
              hcnt_d = hcnt_q;
            end
          endcase
        end
      end

      assign hold[c] = hold_q;
    end else begin : g_nohold
      assign hold[c] = 1'b0;
    end
  end

endmodule

// File: tb/tb_input_debounce_array.sv
// Scoreboard bench: three debouncer configurations share one random stimulus
// stream and are checked every cycle against a window/arithmetic reference model.
`timescale 1ns/1ps
module tb_input_debounce_array;

  localparam int NCH  = 4;
  localparam int ND   = 3;
  localparam int HOLD = 10;

  typedef struct packed {
    logic [NCH-1:0] o;
    logic [NCH-1:0] r;
    logic [NCH-1:0] f;
    logic [NCH-1:0] h;
  } vec_t;

  logic           clk;
  logic           rst_n;
  logic [NCH-1:0] i0, i1, i2;
  logic [NCH-1:0] o0, r0, f0, h0;
  logic [NCH-1:0] o1, r1, f1, h1;
  logic [NCH-1:0] o2, r2, f2, h2;

  input_debounce_array #(.NUM_CH(NCH), .STABLE_CYCLES(4), .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(3), .ACTIVE_LOW(1'b0), .RESET_LEVEL(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .i(i0), .o(o0), .rise(r0), .fall(f0), .hold(h0));

  input_debounce_array #(.NUM_CH(NCH), .STABLE_CYCLES(4), .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(3), .ACTIVE_LOW(1'b1), .RESET_LEVEL(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .i(i1), .o(o1), .rise(r1), .fall(f1), .hold(h1));

  input_debounce_array #(.NUM_CH(NCH), .STABLE_CYCLES(2), .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(0), .ACTIVE_LOW(1'b0), .RESET_LEVEL(1'b0)) u2 (
    .clk(clk), .rst_n(rst_n), .i(i2), .o(o2), .rise(r2), .fall(f2), .hold(h2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   vectors     = 0;
  int   miscompares = 0;
  vec_t q0[$];
  vec_t q1[$];
  vec_t q2[$];

  // Reference model state: logical input history since reset release.
  logic [NCH-1:0] xs[$];
  logic           om[ND][NCH];
  int             re[ND][NCH];
  vec_t           cur[ND];
  logic [NCH-1:0] xa;

  function automatic int stab_of(input int d);
    return (d == 2) ? 2 : 4;
  endfunction

  function automatic int rep_of(input int d);
    return (d == 2) ? 0 : 3;
  endfunction

  // Filtered sample seen at post-reset edge n is the input applied at edge n-2.
  function automatic logic fval(input int c, input int n);
    logic [NCH-1:0] v;
    if (n < 3) return 1'b0;
    v = xs[n-3];
    return v[c];
  endfunction

  task automatic model_reset();
    xs.delete();
    for (int d = 0; d < ND; d++)
      for (int c = 0; c < NCH; c++) begin
        om[d][c] = 1'b0;
        re[d][c] = 0;
      end
  endtask

  task automatic model_step(input logic [NCH-1:0] x);
    int   n;
    int   dd;
    int   s;
    int   rp;
    bit   flip;
    logic nxt;
    vec_t e;
    xs.push_back(x);
    n = xs.size();
    for (int d = 0; d < ND; d++) begin
      e  = '0;
      s  = stab_of(d);
      rp = rep_of(d);
      for (int c = 0; c < NCH; c++) begin
        flip = 1'b1;
        for (int j = n - s + 1; j <= n; j++)
          if (fval(c, j) == om[d][c]) flip = 1'b0;
        nxt    = flip ? ~om[d][c] : om[d][c];
        e.o[c] = nxt;
        e.r[c] = flip & nxt;
        e.f[c] = flip & ~nxt;
        if (om[d][c] && nxt) begin
          dd = n - re[d][c];
          if (dd == HOLD || (rp > 0 && dd > HOLD && ((dd - HOLD) % rp) == 0))
            e.h[c] = 1'b1;
        end
        if (flip && nxt) re[d][c] = n;
        om[d][c] = nxt;
      end
      cur[d] = e;
    end
    q0.push_back(cur[0]);
    q1.push_back(cur[1]);
    q2.push_back(cur[2]);
  endtask

  task automatic push_zero();
    q0.push_back('0);
    q1.push_back('0);
    q2.push_back('0);
  endtask

  task automatic chk(input int d, input vec_t got, input vec_t exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL dut%0d t=%0t got o=%b r=%b f=%b h=%b exp o=%b r=%b f=%b h=%b",
               d, $time, got.o, got.r, got.f, got.h, exp.o, exp.r, exp.f, exp.h);
    end
  endtask

  // Monitor: DUT outputs are presented every cycle; compare on the falling edge.
  always @(negedge clk) begin
    if (q0.size() > 0) chk(0, {o0, r0, f0, h0}, q0.pop_front());
    if (q1.size() > 0) chk(1, {o1, r1, f1, h1}, q1.pop_front());
    if (q2.size() > 0) chk(2, {o2, r2, f2, h2}, q2.pop_front());
  end

  // One clock: account for the edge just passed, then apply the next input.
  task automatic cycle(input logic [NCH-1:0] x, input bit rst);
    @(posedge clk);
    #1;
    if (rst) begin
      rst_n = 1'b0;
      model_reset();
      push_zero();
    end else if (!rst_n) begin
      push_zero();
      rst_n = 1'b1;
    end else begin
      model_step(xa);
    end
    xa = x;
    i0 = x;
    i1 = ~x;
    i2 = x;
  endtask

  task automatic seg(input logic [NCH-1:0] x, input int n);
    repeat (n) cycle(x, 1'b0);
  endtask

  initial begin
    int             left[NCH];
    logic [NCH-1:0] x;
    rst_n = 1'b0;
    xa    = '0;
    i0    = '0;
    i1    = '1;
    i2    = '0;
    model_reset();
    repeat (3) cycle('0, 1'b1);

    // Directed: clean press, glitch train, long presses, reset mid-hold.
    seg(4'b0001, 12);
    seg(4'b0000, 8);
    seg(4'b0001, 3);
    seg(4'b0000, 1);
    seg(4'b0001, 3);
    seg(4'b0000, 8);
    seg(4'b1111, 30);
    seg(4'b0000, 8);
    seg(4'b1111, 22);
    repeat (3) cycle(4'b1111, 1'b1);
    seg(4'b1111, 30);
    seg(4'b0000, 8);

    // Random runs: mostly short bounces, sometimes long presses; ch3 mirrors ch2.
    x = '0;
    for (int c = 0; c < NCH; c++) left[c] = 0;
    for (int k = 0; k < 1500; k++) begin
      for (int c = 0; c < NCH - 1; c++) begin
        if (left[c] == 0) begin
          x[c]    = ~x[c];
          left[c] = ($urandom_range(3, 0) == 0) ? int'($urandom_range(40, 12))
                                                : int'($urandom_range(5, 1));
        end else begin
          left[c]--;
        end
      end
      x[NCH-1] = x[NCH-2];
      cycle(x, (k == 700) || (k == 701) || (k == 1200));
    end
    seg('0, 12);

    @(negedge clk);
    #1;
    if (q0.size() != 0 || q1.size() != 0 || q2.size() != 0) begin
      miscompares++;
      $display("FAIL drain left=%0d required=0", q0.size() + q1.size() + q2.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/input_debounce_array.md
Name: input_debounce_array

Overview:
- Parametrised, multi-channel successor to the single-bit debouncer; filters NUM_CH asynchronous inputs (buttons, switches, encoder contacts) in one clock domain.
- Per channel: 2-flop synchroniser, configurable stability filter, debounced level, one-cycle rise/fall strobes, and long-press/auto-repeat event strobes.
- Sits between board pins and UI/control FSMs; downstream logic consumes strobes directly without its own edge detection.

Parameters:
- NUM_CH, 4, number of independent channels (>=1)
- STABLE_CYCLES, 1000000, consecutive synchronised cycles of disagreement with `o` required to flip `o` (>=1)
- HOLD_CYCLES, 50000000, cycles `o` must stay high before the first `hold` strobe; 0 disables hold and repeat
- REPEAT_CYCLES, 10000000, period of `hold` strobes after the first; 0 gives a single `hold` per press
- ACTIVE_LOW, 0, 1 inverts each input after synchronisation (pull-up buttons read as 1 when pressed)
- RESET_LEVEL, 0, value of every `o` bit after reset (also the level assumed in the synchroniser)

Ports:
- clk  input  1  sole clock
- rst_n  input  1  asynchronous, active-low reset; deassertion synchronous to clk (externally)
- i  input  NUM_CH  raw asynchronous inputs
- o  output  NUM_CH  debounced level per channel
- rise  output  NUM_CH  one-cycle strobe, first cycle `o` is 1
- fall  output  NUM_CH  one-cycle strobe, first cycle `o` is 0
- hold  output  NUM_CH  one-cycle long-press / auto-repeat strobe

Behaviour:
- Reset (rst_n=0, immediate, asynchronous): synchroniser flops = RESET_LEVEL (post-inversion sense), o=RESET_LEVEL, rise=fall=hold=0, all counters 0.
- Synchroniser: s0<=i, s1<=s0; filtered sample f = s1 ^ ACTIVE_LOW. No logic between s0 and s1.
- Stability counter (width $clog2(STABLE_CYCLES+1)), each edge:
  - f == o: cnt<=0.
  - f != o and cnt == STABLE_CYCLES-1: o<=f, cnt<=0.
  - else cnt<=cnt+1.
- Latency: input change sampled by s0 at edge k and held -> o changes at edge k+1+STABLE_CYCLES. Any return of f to o before that restarts the count; no partial credit.
- rise/fall: registered, asserted in exactly the cycle after the edge that changes o; never both; never on reset release.
- Hold counter (width $clog2(max(HOLD_CYCLES,REPEAT_CYCLES)+1)), active only when HOLD_CYCLES>0:
  - Cleared on the edge o rises and whenever o==0.
  - Phase FIRST: counts edges with o==1; at count HOLD_CYCLES-1 -> hold strobe next cycle, counter clear, enter REPEAT (if REPEAT_CYCLES>0) else DONE.
  - Phase REPEAT: strobe every REPEAT_CYCLES edges while o==1.
  - DONE: no strobes until o falls.
  - o falling clears phase to FIRST the same edge; a strobe due on that edge is suppressed.
- Timing: o rises at edge E -> first hold at cycle after edge E+HOLD_CYCLES; repeats after E+HOLD_CYCLES+n*REPEAT_CYCLES.
- Channels fully independent; simultaneous events on different channels all reported in the same cycle.
- Counters never wrap: each compare-and-clear happens before terminal count.
- Reset mid-press: all state discarded; post-reset, a held input re-qualifies from scratch (STABLE_CYCLES+2 cycles) and produces a fresh rise.

Test Plan:
- NUM_CH=2, STABLE=4, HOLD=0: i[0] 0->1 sampled at edge 0 and held -> o[0]=1 after edge 5, rise[0]=1 for exactly that cycle, o[1]/rise[1] stay 0.
- STABLE=4: i[0] pulses high for 3 cycles, low, then high 3 cycles -> o, rise, fall never assert; counter observed returning to 0.
- STABLE=4: established o=1, i drops for 4+ cycles -> o=0 at edge k+5, fall=1 one cycle; ACTIVE_LOW=1 run with inverted stimulus gives identical o/rise/fall.
- STABLE=2, HOLD=10, REPEAT=3: hold input 30 cycles after o rises at E -> hold strobes at E+10, E+13, E+16, ... ; release -> strobes stop, fall asserted, next press restarts at +10. REPEAT=0 -> single strobe at E+10.
- Both channels toggled same cycle with identical stimulus -> o, rise, fall, hold bit-identical across channels every cycle.
- Assert rst_n=0 asynchronously mid-hold (between clock edges) -> all outputs 0 immediately; release with input still high -> rise after STABLE+2 edges, hold timer restarts from zero.
